line_mem_responder: RTL and testbench
=====================================

# line_mem_responder

Memory-side responder for the cache's 128-bit line interface: it accepts one line read or line write at a time from the cache datapath/control, waits a programmable latency, then returns `mem_resp` for one cycle, with read data where applicable. It sits between the cache and the (modelled) physical memory. It also serves as the synthesizable main-memory stand-in for cache bring-up and regression.

## Interface
Parameters:
- `LATENCY`, default 4: cycles from request acceptance to `mem_resp`; legal range 1..15.
- `LINE_BITS`, default 8: number of line-index bits taken from `mem_address[LINE_BITS+3:4]`. Depth is 2^LINE_BITS lines of 16 bytes.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `mem_read`  in  1: line read request, held by the requester until `mem_resp`.
- `mem_write`  in  1: line write request, held by the requester until `mem_resp`.
- `mem_address`  in  16 (`lc3b_word`): byte address; bits [3:0] are ignored.
- `mem_wdata`  in  128: write line.
- `mem_byte_enable`  in  2: the cache always drives 2'b11; ignored, every write is a full line.
- `mem_resp`  out  1: one-cycle completion pulse.
- `mem_rdata`  out  128: read line, valid in the `mem_resp` cycle and held until the next read completes.
- `proto_err`  out  1: sticky flag for protocol violations; cleared only by reset.

## Operation
- FSM has three states: IDLE, BUSY, RESP.
- IDLE
  - If `mem_read | mem_write` is high, accept the request. Latch the line index, the op (`write` wins if both are high), and `mem_wdata`.
  - Load the down-counter with LATENCY-1.
  - If LATENCY==1, go straight to RESP; otherwise go to BUSY.
- BUSY
  - Decrement the counter each cycle; go to RESP when it reaches 1.
  - Latched values are used and request lines are ignored, so a requester that drops its request mid-flight does not abort the operation.
- RESP
  - Assert `mem_resp`.
  - Read: `mem_rdata` shows the stored line for the latched index.
  - Write: the latched line is committed to storage at the edge that ends RESP.
  - Always return to IDLE.
- IDLE after RESP
  - A request still high in that cycle is accepted as a new request.
  - The cache control drops its request in the state it moves to after `mem_resp`, so no back-to-back duplicate occurs.
- `proto_err` sets on either of these:
  - `mem_read & mem_write` both high in IDLE.
  - The request deasserted while in BUSY or RESP.
- Storage is never cleared by reset. Simulation initialises it to all zeros.
- Read-after-write: a read accepted after a write's RESP returns the new line.

## Timing
- Reset values (applied at the next edge while `reset` is high, regardless of state):
  - State: IDLE, counter 0.
  - Outputs: `mem_resp` 0, `mem_rdata` 128'h0, `proto_err` 0.
  - An in-flight write is discarded, with no commit.
- Latency: request accepted at edge T, then `mem_resp` is high during cycle T+LATENCY, for exactly one cycle.
  - Example: LATENCY=4 with a request first seen high in cycle 0 gives `mem_resp` in cycle 4.
- Throughput: one access per LATENCY+1 cycles under back-to-back requests.
- `mem_rdata` is registered. It updates on entry to RESP for reads and is unchanged by writes.
- Line index wrap-around: upper address bits above LINE_BITS+3 alias. With LINE_BITS=8, addresses 0x1230 and 0x0230 name the same line.

## Structure
- Shared `lc3b_types` package:
  - Add `lc3b_line` (`logic [127:0]`).
  - Add the state enum `lc3b_mresp_state_t` {IDLE, BUSY, RESP}.
- One sub-module, `line_store`, a parameterized (`width`, `index_bits`) single-port array:
  - Synchronous write, combinational read, no reset.
  - Matches the existing `array` style, deepened for memory size.
- Top level holds the FSM, the counter, the latch registers and `proto_err`.

## Test plan
- Reset: assert `reset` mid-BUSY of a write to 0x0040 with line 128'hA5..A5, then issue a read of 0x0040 → `mem_resp` at T+4 and `mem_rdata`==0 (the write was discarded).
- Write then read, LATENCY=4: write 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210 to 0x1230 → `mem_resp` in cycle 4. Then read 0x1238 → the same line, with `mem_resp` exactly 4 cycles after acceptance.
- Back-to-back: hold `mem_read` high across RESP for 0x0010 then 0x0020 → two `mem_resp` pulses 5 cycles apart, each with its own line.
- LATENCY=1: read 0x0050 → `mem_resp` in the cycle after acceptance, held low in all other cycles.
- Aliasing: write line X to 0x0230, then read 0x1230 (LINE_BITS=8) → returns X.
- Protocol error:
  - `mem_read` and `mem_write` high together → write performed and `proto_err`=1, staying 1 until reset.
  - Dropping `mem_read` in BUSY → `mem_resp` still pulses and `proto_err`=1.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b types: word/line containers and the memory responder FSM states.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_line;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } lc3b_mresp_state_t;

  localparam int LC3B_LINE_OFFSET_BITS = 4;

  // Drops the byte-within-line offset; callers keep as many index bits as they need.
  function automatic logic [11:0] line_of(input lc3b_word addr);
    return addr[15:LC3B_LINE_OFFSET_BITS];
  endfunction

endpackage

// File: rtl/line_store.sv
// Single-port line array: synchronous write, combinational read, never reset.
// Latency: write visible on the cycle after the write edge.
// Backpressure: none; one access per cycle.
module line_store #(
  parameter int width      = 128,
  parameter int index_bits = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [index_bits-1:0] index,
  input  logic [width-1:0]      datain,
  output logic [width-1:0]      dataout
);

  // Declaration initialiser gives simulation its all-zero contents without a reset.
  logic [width-1:0] data [2**index_bits] = '{default: '0};

  always_ff @(posedge clk) begin
    if (we) begin
      data[index] <= datain;
    end
  end

  assign dataout = data[index];

endmodule

// File: rtl/line_mem_responder.sv
// Main-memory stand-in for the cache's 128-bit line port, one access in flight at a time.
// Latency: mem_resp pulses LATENCY cycles after the accepting edge; writes commit as RESP ends.
// Backpressure: requester holds mem_read/mem_write until mem_resp; new request taken in IDLE only.
module line_mem_responder
  import lc3b_types::*;
#(
  parameter int LATENCY   = 4,
  parameter int LINE_BITS = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mem_read,
  input  logic       mem_write,
  input  lc3b_word   mem_address,
  input  lc3b_line   mem_wdata,
  input  logic [1:0] mem_byte_enable,
  output logic       mem_resp,
  output lc3b_line   mem_rdata,
  output logic       proto_err
);

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  lc3b_mresp_state_t    state;
  logic [3:0]           cnt;
  logic [LINE_BITS-1:0] idx_q;
  logic [LINE_BITS-1:0] addr_idx;
  logic [LINE_BITS-1:0] store_idx;
  logic                 op_write;
  lc3b_line             wdata_q;
  lc3b_line             store_rdata;
  logic                 req;
  logic                 store_we;
  logic                 unused_bits;

  assign req       = mem_read | mem_write;
  assign addr_idx  = LINE_BITS'(line_of(mem_address));
  // In IDLE the array is addressed straight from the port so LATENCY==1 reads work.
  assign store_idx = (state == IDLE) ? addr_idx : idx_q;
  assign store_we  = (state == RESP) && op_write && !reset;

  // Full-line writes only; byte enables and alias bits carry no information here.
  assign unused_bits = ^{mem_byte_enable, mem_address};

  line_store #(
    .width      (128),
    .index_bits (LINE_BITS)
  ) u_store (
    .clk     (clk),
    .we      (store_we),
    .index   (store_idx),
    .datain  (wdata_q),
    .dataout (store_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      idx_q     <= '0;
      op_write  <= 1'b0;
      wdata_q   <= '0;
      mem_resp  <= 1'b0;
      mem_rdata <= '0;
      proto_err <= 1'b0;
    end else begin
      mem_resp <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_read && mem_write) begin
            proto_err <= 1'b1;
          end
          if (req) begin
            idx_q    <= addr_idx;
            op_write <= mem_write;
            wdata_q  <= mem_wdata;
            cnt      <= CNT_INIT;
            if (LATENCY == 1) begin
              state    <= RESP;
              mem_resp <= 1'b1;
              if (!mem_write) begin
                mem_rdata <= store_rdata;
              end
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (!req) begin
            proto_err <= 1'b1;
          end
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state    <= RESP;
            mem_resp <= 1'b1;
            if (!op_write) begin
              mem_rdata <= store_rdata;
            end
          end
        end
        RESP: begin
          if (!req) begin
            proto_err <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_mem_responder.sv
// Directed bench for line_mem_responder: one LATENCY=4 instance and one LATENCY=1 instance.
module tb_line_mem_responder;
  import lc3b_types::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       read_a, write_a, resp_a, err_a;
  lc3b_word   addr_a;
  lc3b_line   wdata_a, rdata_a;
  logic       read_b, write_b, resp_b, err_b;
  lc3b_word   addr_b;
  lc3b_line   wdata_b, rdata_b;

  int checks = 0;
  int errors = 0;

  localparam lc3b_line LA5 = {16{8'hA5}};
  localparam lc3b_line LW  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam lc3b_line L1  = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam lc3b_line L2  = 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000;
  localparam lc3b_line LX  = 128'hDEAD_BEEF_0000_1111_CAFE_F00D_2222_3333;
  localparam lc3b_line LY  = 128'h0F0F_0F0F_1234_5678_F0F0_F0F0_8765_4321;
  localparam lc3b_line LZ  = 128'h5A5A_5A5A_A5A5_A5A5_0001_0002_0003_0004;

  line_mem_responder #(.LATENCY(4), .LINE_BITS(8)) dut_a (
    .clk(clk), .reset(reset), .mem_read(read_a), .mem_write(write_a),
    .mem_address(addr_a), .mem_wdata(wdata_a), .mem_byte_enable(2'b11),
    .mem_resp(resp_a), .mem_rdata(rdata_a), .proto_err(err_a)
  );

  line_mem_responder #(.LATENCY(1), .LINE_BITS(8)) dut_b (
    .clk(clk), .reset(reset), .mem_read(read_b), .mem_write(write_b),
    .mem_address(addr_b), .mem_wdata(wdata_b), .mem_byte_enable(2'b11),
    .mem_resp(resp_b), .mem_rdata(rdata_b), .proto_err(err_b)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic rd, input logic wr,
                       input lc3b_word a, input lc3b_line d);
    if (sel) begin
      read_b = rd; write_b = wr; addr_b = a; wdata_b = d;
    end else begin
      read_a = rd; write_a = wr; addr_a = a; wdata_a = d;
    end
  endtask

  function automatic logic get_resp(input bit sel);
    return sel ? resp_b : resp_a;
  endfunction

  function automatic lc3b_line get_rdata(input bit sel);
    return sel ? rdata_b : rdata_a;
  endfunction

  // Request raised at the start of cycle 0; mem_resp expected in cycle exp_lat only.
  // drop_k >= 0 releases the request at the negedge of that cycle.
  task automatic access(input string tag, input bit sel, input logic rd, input logic wr,
                        input lc3b_word a, input lc3b_line d, input int exp_lat,
                        input int drop_k, output lc3b_line seen);
    int found;
    found = -1;
    seen  = '0;
    @(posedge clk); #1;
    drive(sel, rd, wr, a, d);
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk);
      if (get_resp(sel)) begin
        found = k;
        seen  = get_rdata(sel);
        break;
      end
      if (k == drop_k) drive(sel, 1'b0, 1'b0, a, d);
    end
    chk({tag, " latency"}, 128'(found), 128'(exp_lat));
    @(posedge clk); #1;
    drive(sel, 1'b0, 1'b0, a, d);
    @(negedge clk);
    chk({tag, " single pulse"}, 128'(get_resp(sel)), 128'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    lc3b_line seen;
    int p1, p2, npulse;
    lc3b_line d1, d2;

    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 16'h0, '0);
    drive(1'b1, 1'b0, 1'b0, 16'h0, '0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset resp", 128'(resp_a), 128'(0));
    chk("reset rdata", rdata_a, '0);
    chk("reset proto_err", 128'(err_a), 128'(0));
    chk("reset resp lat1", 128'(resp_b), 128'(0));

    // Write interrupted by reset in BUSY must never reach storage.
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b1, 16'h0040, LA5);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 16'h0040, '0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("mid-busy reset resp", 128'(resp_a), 128'(0));
    chk("mid-busy reset proto_err", 128'(err_a), 128'(0));
    access("discarded read", 1'b0, 1'b1, 1'b0, 16'h0040, '0, 4, -1, seen);
    chk("discarded write data", seen, '0);

    access("write 1230", 1'b0, 1'b0, 1'b1, 16'h1230, LW, 4, -1, seen);
    access("read 1238", 1'b0, 1'b1, 1'b0, 16'h1238, '0, 4, -1, seen);
    chk("read 1238 data", seen, LW);
    chk("no proto_err after clean traffic", 128'(err_a), 128'(0));

    access("write 0010", 1'b0, 1'b0, 1'b1, 16'h0010, L1, 4, -1, seen);
    access("write 0020", 1'b0, 1'b0, 1'b1, 16'h0020, L2, 4, -1, seen);

    // Back-to-back: read stays high across RESP, address moves to the next line.
    p1 = -1; p2 = -1; npulse = 0; d1 = '0; d2 = '0;
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, 16'h0010, '0);
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (resp_a) begin
        npulse++;
        if (p1 < 0) begin
          p1 = k; d1 = rdata_a;
        end else begin
          p2 = k; d2 = rdata_a;
        end
      end
      @(posedge clk); #1;
      if (k == p1) addr_a = 16'h0020;
      if (k == p2) drive(1'b0, 1'b0, 1'b0, 16'h0020, '0);
    end
    chk("b2b first latency", 128'(p1), 128'(4));
    chk("b2b spacing", 128'(p2 - p1), 128'(5));
    chk("b2b first data", d1, L1);
    chk("b2b second data", d2, L2);
    chk("b2b pulse count", 128'(npulse), 128'(2));
    chk("b2b proto_err", 128'(err_a), 128'(0));

    access("alias write 0230", 1'b0, 1'b0, 1'b1, 16'h0230, LX, 4, -1, seen);
    access("alias read 1230", 1'b0, 1'b1, 1'b0, 16'h1230, '0, 4, -1, seen);
    chk("alias data", seen, LX);

    access("lat1 write 0050", 1'b1, 1'b0, 1'b1, 16'h0050, LY, 1, -1, seen);
    access("lat1 read 0050", 1'b1, 1'b1, 1'b0, 16'h0050, '0, 1, -1, seen);
    chk("lat1 read data", seen, LY);
    chk("lat1 proto_err", 128'(err_b), 128'(0));

    access("both high", 1'b0, 1'b1, 1'b1, 16'h0300, LZ, 4, -1, seen);
    chk("both high proto_err", 128'(err_a), 128'(1));
    chk("both high rdata untouched by write", rdata_a, LX);
    access("read after both", 1'b0, 1'b1, 1'b0, 16'h0300, '0, 4, -1, seen);
    chk("write won", seen, LZ);
    chk("proto_err sticky", 128'(err_a), 128'(1));

    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("proto_err cleared by reset", 128'(err_a), 128'(0));

    access("drop in busy", 1'b0, 1'b1, 1'b0, 16'h0300, '0, 4, 2, seen);
    chk("drop in busy data", seen, LZ);
    chk("drop in busy proto_err", 128'(err_a), 128'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
